// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the PE layer controller.
//   state_e           : controller state encoding
//   DEFAULT_BIAS_BASE : default base address of the bias block in PE memory
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_K = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_LOAD_S = 3'd3,
    ST_RUN    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic [31:0] DEFAULT_BIAS_BASE = 32'h0000_1000;

endpackage : pe_ctrl_pkg

// File: rtl/pe_layer_ctrl.sv
// -----------------------------------------------------------------------------
// pe_layer_ctrl
// Sequences one layer run of a processing element: streams kernel weights,
// biases and an optional layer-scale word into PE memory, then issues
// NUM_WINDOWS input windows and waits for the matching results.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort      : single-cycle control pulses
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse when the layer run completes
//   err               : sticky protocol error, cleared by reset or start
//   s_wdata/s_wvalid/s_wready : weight stream in (valid/ready)
//   weight_wr_*       : registered write port into PE memory (latency 1)
//   s_win_valid/s_win_ready   : upstream window handshake
//   pe_i_valid, pe_ack, pe_o_valid : PE issue / accept / result strobes
// -----------------------------------------------------------------------------
module pe_layer_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int          OUT_CHANNEL = 4,
  parameter int          IN_CHANNEL  = 2,
  parameter int          KERNEL_PTS  = 9,
  parameter int          NUM_WINDOWS = 9,
  parameter bit          HAS_SCALE   = 1'b0,
  parameter logic [31:0] BIAS_BASE   = DEFAULT_BIAS_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [15:0] s_wdata,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [15:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  input  logic        s_win_valid,
  output logic        s_win_ready,
  output logic        pe_i_valid,
  input  logic        pe_ack,
  input  logic        pe_o_valid
);

  localparam int K_TOTAL = OUT_CHANNEL * IN_CHANNEL * KERNEL_PTS;
  // One load counter serves both the kernel and the bias phase.
  localparam int LD_MAX  = (K_TOTAL > OUT_CHANNEL) ? K_TOTAL : OUT_CHANNEL;
  localparam int LD_W    = $clog2(LD_MAX + 1);
  localparam int WIN_W   = $clog2(NUM_WINDOWS + 1);

  localparam logic [LD_W-1:0]  K_LAST  = LD_W'(K_TOTAL - 1);
  localparam logic [LD_W-1:0]  B_LAST  = LD_W'(OUT_CHANNEL - 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(NUM_WINDOWS);
  localparam logic [31:0]      SCALE_ADDR = BIAS_BASE + 32'(OUT_CHANNEL);

  state_e            state_q, state_d;
  logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [WIN_W-1:0]  issued_q, issued_d;
  logic [WIN_W-1:0]  received_q, received_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;

  logic              loading;
  logic              in_run;
  logic              collecting;
  logic              beat;
  logic              issue_fire;
  logic              rcv_fire;
  logic              start_acc;
  logic              err_set;
  logic [31:0]       beat_addr;

  // ---------------------------------------------------------------------------
  // State decode and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    loading    = (state_q == ST_LOAD_K) || (state_q == ST_LOAD_B) ||
                 (state_q == ST_LOAD_S);
    in_run     = (state_q == ST_RUN);
    collecting = in_run || (state_q == ST_DRAIN);

    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    s_wready   = loading;
    beat       = s_wvalid && loading;

    // Windows are offered only while some remain to be issued.
    pe_i_valid  = in_run && s_win_valid && (issued_q < WIN_MAX);
    s_win_ready = in_run && pe_ack;

    issue_fire = pe_i_valid && pe_ack;
    // Saturate at NUM_WINDOWS so an over-delivering PE cannot wrap the count;
    // the overrun itself is flagged through err.
    rcv_fire   = collecting && pe_o_valid && (received_q < WIN_MAX);
    start_acc  = (state_q == ST_IDLE) && start && !abort;
  end

  // Address of the word accepted this cycle, by load phase.
  always_comb begin
    beat_addr = 32'h0;
    unique case (state_q)
      ST_LOAD_K: beat_addr = 32'(ld_cnt_q);
      ST_LOAD_B: beat_addr = BIAS_BASE + 32'(ld_cnt_q);
      ST_LOAD_S: beat_addr = SCALE_ADDR;
      default:   beat_addr = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    issued_d   = issued_q;
    received_d = received_q;

    // Both counters move in the same cycle when an ack and a result coincide.
    if (issue_fire) issued_d   = issued_q + WIN_W'(1);
    if (rcv_fire)   received_d = received_q + WIN_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD_K;
          ld_cnt_d   = '0;
          issued_d   = '0;
          received_d = '0;
        end
      end
      ST_LOAD_K: begin
        if (beat) begin
          if (ld_cnt_q == K_LAST) begin
            state_d  = ST_LOAD_B;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (beat) begin
          if (ld_cnt_q == B_LAST) begin
            state_d  = HAS_SCALE ? ST_LOAD_S : ST_RUN;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_W'(1);
          end
        end
      end
      ST_LOAD_S: begin
        if (beat) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (issued_d == WIN_MAX) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (received_d == WIN_MAX) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort outranks start and every state advance.
    if (abort) begin
      state_d    = ST_IDLE;
      ld_cnt_d   = '0;
      issued_d   = '0;
      received_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------------
  always_comb begin
    err_set = 1'b0;
    if (pe_o_valid && ((state_q == ST_IDLE) || loading)) err_set = 1'b1;
    if (pe_ack && !pe_i_valid)                           err_set = 1'b1;
    // A result with no outstanding issue, counting an ack in the same cycle.
    if (collecting && pe_o_valid && (received_q >= issued_d)) err_set = 1'b1;

    err_d = err_q;
    if (start_acc) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registered PE write port. Not gated by abort: a word accepted in the abort
  // cycle still lands one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en_d   = beat;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (beat) begin
      wr_addr_d = beat_addr;
      wr_data_d = s_wdata;
    end
  end

  // NOTE: asynchronous active-high reset sits in the sensitivity list; state
  // updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ld_cnt_q   <= '0;
      issued_q   <= '0;
      received_q <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'h0;
      wr_data_q  <= 16'h0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign err            = err_q;
  assign weight_wr_en   = wr_en_q;
  assign weight_wr_addr = wr_addr_q;
  assign weight_wr_data = wr_data_q;

endmodule : pe_layer_ctrl

// File: tb/tb_pe_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_layer_ctrl
// Drives two controllers: dut (defaults, no scale word) and dut_s (HAS_SCALE=1).
// Expected PE writes are queued when a weight beat is accepted and popped by a
// per-DUT write monitor.
// -----------------------------------------------------------------------------
module tb_pe_layer_ctrl;

  localparam int          OC        = 4;
  localparam int          IC        = 2;
  localparam int          KP        = 9;
  localparam int          NUM_WIN   = 9;
  localparam int          K_TOTAL   = OC * IC * KP;
  localparam logic [31:0] BASE      = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, start_s;
  logic [15:0] s_wdata;
  logic        s_wvalid, s_wvalid_s;
  logic        s_win_valid, pe_ack, pe_o_valid;

  logic        busy, done, err, s_wready, s_win_ready, pe_i_valid;
  logic [15:0] weight_wr_data;
  logic [31:0] weight_wr_addr;
  logic        weight_wr_en;

  logic        busy_s, done_s, err_s, s_wready_s, s_win_ready_s, pe_i_valid_s;
  logic [15:0] weight_wr_data_s;
  logic [31:0] weight_wr_addr_s;
  logic        weight_wr_en_s;

  wr_t exp_q[$];
  wr_t exp_s_q[$];
  int  n_checks   = 0;
  int  n_errors   = 0;
  int  wr_count   = 0;
  int  wr_count_s = 0;
  int  cyc        = 0;

  pe_layer_ctrl #(
    .OUT_CHANNEL(OC), .IN_CHANNEL(IC), .KERNEL_PTS(KP),
    .NUM_WINDOWS(NUM_WIN), .HAS_SCALE(1'b0), .BIAS_BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
    .weight_wr_en(weight_wr_en),
    .s_win_valid(s_win_valid), .s_win_ready(s_win_ready),
    .pe_i_valid(pe_i_valid), .pe_ack(pe_ack), .pe_o_valid(pe_o_valid)
  );

  pe_layer_ctrl #(
    .OUT_CHANNEL(OC), .IN_CHANNEL(IC), .KERNEL_PTS(KP),
    .NUM_WINDOWS(NUM_WIN), .HAS_SCALE(1'b1), .BIAS_BASE(BASE)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort),
    .busy(busy_s), .done(done_s), .err(err_s),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid_s), .s_wready(s_wready_s),
    .weight_wr_data(weight_wr_data_s), .weight_wr_addr(weight_wr_addr_s),
    .weight_wr_en(weight_wr_en_s),
    .s_win_valid(1'b0), .s_win_ready(s_win_ready_s),
    .pe_i_valid(pe_i_valid_s), .pe_ack(1'b0), .pe_o_valid(1'b0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the load stream: word index -> address / data.
  function automatic logic [31:0] exp_addr(input int idx);
    if (idx < K_TOTAL)           return 32'(idx);
    else if (idx < K_TOTAL + OC) return BASE + 32'(idx - K_TOTAL);
    else                         return BASE + 32'(OC);
  endfunction

  function automatic logic [15:0] exp_data(input int idx);
    if (idx < K_TOTAL)           return 16'(idx + 1);
    else if (idx < K_TOTAL + OC) return 16'((idx - K_TOTAL) * 10);
    else                         return 16'h0100;
  endfunction

  // Write monitors: each write must match the oldest accepted beat and land
  // exactly one cycle after it.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && weight_wr_en === 1'b1) begin
      wr_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_spurious: addr=%h data=%h with no beat pending", weight_wr_addr, weight_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (weight_wr_addr !== e.addr || weight_wr_data !== e.data || cyc != e.cyc + 1) begin
          n_errors++;
          $display("FAIL wr_match: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                   weight_wr_addr, weight_wr_data, cyc, e.addr, e.data, e.cyc + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && weight_wr_en_s === 1'b1) begin
      wr_count_s++;
      n_checks++;
      if (exp_s_q.size() == 0) begin
        n_errors++;
        $display("FAIL wr_s_spurious: addr=%h data=%h with no beat pending", weight_wr_addr_s, weight_wr_data_s);
      end else begin
        e = exp_s_q.pop_front();
        if (weight_wr_addr_s !== e.addr || weight_wr_data_s !== e.data || cyc != e.cyc + 1) begin
          n_errors++;
          $display("FAIL wr_s_match: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                   weight_wr_addr_s, weight_wr_data_s, cyc, e.addr, e.data, e.cyc + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Streams n_words words starting at index 0; optionally valid on every other
  // cycle, optionally asserting abort together with word number abort_at.
  task automatic load_stream(input int n_words, input bit toggle,
                             input int abort_at, input bit to_scale);
    int   sent;
    bit   v;
    logic rdy;
    sent = 0;
    for (int c = 0; c < 600 && sent < n_words; c++) begin
      v          = !toggle || (c % 2 == 0);
      s_wdata    = exp_data(sent);
      s_wvalid   = v && !to_scale;
      s_wvalid_s = v && to_scale;
      abort      = (abort_at > 0) && v && (sent == abort_at - 1);
      @(negedge clk);
      rdy = to_scale ? s_wready_s : s_wready;
      if (v && rdy === 1'b1) begin
        if (to_scale) exp_s_q.push_back('{exp_addr(sent), exp_data(sent), cyc});
        else          exp_q.push_back('{exp_addr(sent), exp_data(sent), cyc});
        sent++;
      end
      tick();
    end
    s_wvalid   = 1'b0;
    s_wvalid_s = 1'b0;
    abort      = 1'b0;
    n_checks++;
    if (sent != n_words) begin
      n_errors++;
      $display("FAIL load_beats: accepted=%0d want=%0d", sent, n_words);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, err, s_wready, s_win_ready, pe_i_valid, weight_wr_en} !== 7'b0 ||
        weight_wr_addr !== 32'h0 || weight_wr_data !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: ctl=%b addr=%h data=%h want all zero",
               {busy, done, err, s_wready, s_win_ready, pe_i_valid, weight_wr_en},
               weight_wr_addr, weight_wr_data);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || s_wready !== 1'b0 || busy_s !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_idle: busy=%b s_wready=%b busy_s=%b want 0", busy, s_wready, busy_s);
    end
  endtask

  task automatic test_load();
    wr_count = 0;
    pulse_start();
    load_stream(K_TOTAL + OC, 1'b0, 0, 1'b0);
    tick();
    n_checks++;
    if (wr_count != K_TOTAL + OC || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL load_count: writes=%0d pending=%0d want %0d/0", wr_count, exp_q.size(), K_TOTAL + OC);
    end
    n_checks++;
    if (busy !== 1'b1 || s_wready !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL load_to_run: busy=%b s_wready=%b err=%b want 1/0/0", busy, s_wready, err);
    end
  endtask

  task automatic test_run();
    int ov_q[$];
    int acks = 0, ovs = 0, done_cnt = 0, done_cyc = -1, last_ov = -1, ack9 = -1;
    s_win_valid = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      pe_ack     = (k % 3 == 0) && (acks < NUM_WIN);
      pe_o_valid = (ov_q.size() > 0) && (ov_q[0] == k);
      if (pe_o_valid) void'(ov_q.pop_front());
      @(negedge clk);
      if (pe_ack) begin
        n_checks++;
        if (pe_i_valid !== 1'b1 || s_win_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL run_handshake: k=%0d pe_i_valid=%b s_win_ready=%b want 1/1", k, pe_i_valid, s_win_ready);
        end
        acks++;
        ov_q.push_back(k + 5);
        if (acks == NUM_WIN) ack9 = k;
      end
      if (ack9 > 0 && k == ack9 + 1) begin
        n_checks++;
        if (pe_i_valid !== 1'b0 || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL run_drain: pe_i_valid=%b busy=%b want 0/1", pe_i_valid, busy);
        end
      end
      if (pe_o_valid) begin
        ovs++;
        last_ov = k;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      if (done_cyc > 0 && k == done_cyc + 1) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_errors++;
          $display("FAIL run_busy_after_done: busy=%b want 0", busy);
        end
      end
      tick();
    end
    pe_ack      = 1'b0;
    pe_o_valid  = 1'b0;
    s_win_valid = 1'b0;
    n_checks++;
    if (acks != NUM_WIN || ovs != NUM_WIN) begin
      n_errors++;
      $display("FAIL run_counts: acks=%0d results=%0d want %0d", acks, ovs, NUM_WIN);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != last_ov + 1) begin
      n_errors++;
      $display("FAIL run_done_pulse: pulses=%0d at=%0d want 1 at %0d", done_cnt, done_cyc, last_ov + 1);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL run_err: err=%b want 0", err);
    end
  endtask

  task automatic test_load_toggle();
    wr_count = 0;
    pulse_start();
    load_stream(K_TOTAL + OC, 1'b1, 0, 1'b0);
    tick();
    n_checks++;
    if (wr_count != K_TOTAL + OC || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL toggle_count: writes=%0d pending=%0d want %0d/0", wr_count, exp_q.size(), K_TOTAL + OC);
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    wr_count = 0;
    pulse_start();
    load_stream(40, 1'b0, 40, 1'b0);
    #1;
    n_checks++;
    if (busy !== 1'b0 || s_wready !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle: busy=%b s_wready=%b want 0/0", busy, s_wready);
    end
    tick();
    n_checks++;
    if (wr_count != 40 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL abort_writes: writes=%0d pending=%0d want 40/0", wr_count, exp_q.size());
    end
    wr_count = 0;
    pulse_start();
    load_stream(K_TOTAL + OC, 1'b0, 0, 1'b0);
    tick();
    n_checks++;
    if (wr_count != K_TOTAL + OC || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL abort_reload: writes=%0d pending=%0d want %0d/0", wr_count, exp_q.size(), K_TOTAL + OC);
    end
    pulse_abort();
  endtask

  task automatic test_err();
    pe_o_valid = 1'b1;
    tick();
    pe_o_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_idle_ovalid: err=%b want 1", err);
    end
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL err_start_clear: err=%b busy=%b want 0/1", err, busy);
    end
    pe_ack = 1'b1;
    tick();
    pe_ack = 1'b0;
    pulse_abort();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL err_ack_sticky: err=%b busy=%b want 1/0", err, busy);
    end
    pulse_start();
    pulse_abort();
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_restart_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_scale();
    wr_count_s = 0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    load_stream(K_TOTAL + OC + 1, 1'b0, 0, 1'b1);
    tick();
    n_checks++;
    if (wr_count_s != K_TOTAL + OC + 1 || exp_s_q.size() != 0) begin
      n_errors++;
      $display("FAIL scale_count: writes=%0d pending=%0d want %0d/0", wr_count_s, exp_s_q.size(), K_TOTAL + OC + 1);
    end
    n_checks++;
    if (busy_s !== 1'b1 || s_wready_s !== 1'b0 || err_s !== 1'b0) begin
      n_errors++;
      $display("FAIL scale_to_run: busy=%b s_wready=%b err=%b want 1/0/0", busy_s, s_wready_s, err_s);
    end
    pulse_abort();
    n_checks++;
    if (busy_s !== 1'b0) begin
      n_errors++;
      $display("FAIL scale_abort: busy=%b want 0", busy_s);
    end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; start_s = 1'b0;
    s_wdata = 16'h0; s_wvalid = 1'b0; s_wvalid_s = 1'b0;
    s_win_valid = 1'b0; pe_ack = 1'b0; pe_o_valid = 1'b0;
    test_reset();
    test_load();
    test_run();
    test_load_toggle();
    test_abort();
    test_err();
    test_scale();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_pe_layer_ctrl
